// File: rtl/pygmy_bus_pkg.sv
// Shared LSU-bus definitions: access-size encodings, timer register offsets and bit positions,
// plus the lane helpers every responder uses to turn a right-aligned write into byte enables.
package pygmy_bus_pkg;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    localparam logic [3:0] TMR_CTRL    = 4'h0;
    localparam logic [3:0] TMR_COUNT   = 4'h4;
    localparam logic [3:0] TMR_COMPARE = 4'h8;
    localparam logic [3:0] TMR_STATUS  = 4'hC;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_PRESCALE    = 8;

    localparam int STATUS_MATCH = 0;
    localparam int STATUS_OVF   = 1;

    // A misaligned half access yields no enables, so the write is dropped.
    function automatic logic [3:0] lane_be(input logic [1:0] hb, input logic [1:0] lane);
        case (hb)
            HB_BYTE: return 4'b0001 << lane;
            HB_HALF: return lane[0] ? 4'b0000 : (lane[1] ? 4'b1100 : 4'b0011);
            HB_WORD: return 4'b1111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_align(input logic [1:0] hb, input logic [31:0] wdata);
        case (hb)
            HB_BYTE: return {4{wdata[7:0]}};
            HB_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val, input logic [31:0] data,
                                               input logic [3:0] be);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = data[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the system clock by PRESCALE+1 while enabled; the tick is high for the cycle in which
// the phase counter equals PRESCALE. Disable or clear restarts the phase from zero.
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] r_cnt;

    assign tick_o = en_i & ~clear_i & (r_cnt == prescale_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i || clear_i) begin
            r_cnt <= '0;
        end else if (r_cnt == prescale_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer on the LSU bus: register file with lane-merged writes, prescaled 32-bit
// counter with compare/overflow flags, combinational read mux and a level interrupt.
module bus_timer
    import pygmy_bus_pkg::*;
#(
    parameter int          PRESCALE_W    = 8,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  hb_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam logic [31:0] CTRL_MASK =
        ((32'(2**PRESCALE_W) - 32'd1) << CTRL_PRESCALE) | 32'h0000_0007;

    logic [31:0] r_ctrl;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [1:0]  r_status;

    logic        w_wr;
    logic [1:0]  w_sel;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_wr_ctrl, w_wr_count, w_wr_compare, w_wr_status;
    logic        w_tick;
    logic [31:0] w_count_tick;
    logic        w_match_set, w_ovf_set;
    logic [1:0]  w_status_clr;
    logic        w_unused;

    assign w_unused     = ^addr_i[31:4];
    assign w_wr         = cs_i & we_i;
    assign w_sel        = addr_i[3:2];
    assign w_be         = lane_be(hb_i, addr_i[1:0]);
    assign w_wdata      = lane_align(hb_i, wdata_i);
    assign w_wr_ctrl    = w_wr && (w_sel == TMR_CTRL[3:2]);
    assign w_wr_count   = w_wr && (w_sel == TMR_COUNT[3:2]);
    assign w_wr_compare = w_wr && (w_sel == TMR_COMPARE[3:2]);
    assign w_wr_status  = w_wr && (w_sel == TMR_STATUS[3:2]);
    assign w_status_clr = (w_wr_status && w_be[0]) ? w_wdata[1:0] : 2'b00;

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (r_ctrl[CTRL_EN]),
        .clear_i    (w_wr_ctrl),
        .prescale_i (r_ctrl[CTRL_PRESCALE +: PRESCALE_W]),
        .tick_o     (w_tick)
    );

    // Compare has priority over the overflow wrap when COMPARE is all ones.
    always_comb begin
        w_count_tick = r_count;
        w_match_set  = 1'b0;
        w_ovf_set    = 1'b0;
        if (w_tick) begin
            if (r_count == r_compare) begin
                w_match_set  = 1'b1;
                w_count_tick = r_ctrl[CTRL_AUTO_RELOAD] ? 32'h0 : r_count + 32'd1;
            end else if (r_count == 32'hFFFF_FFFF) begin
                w_ovf_set    = 1'b1;
                w_count_tick = 32'h0;
            end else begin
                w_count_tick = r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl    <= 32'h0;
            r_count   <= 32'h0;
            r_compare <= RESET_COMPARE;
            r_status  <= 2'b00;
        end else begin
            if (w_wr_ctrl)    r_ctrl    <= lane_merge(r_ctrl, w_wdata, w_be) & CTRL_MASK;
            if (w_wr_compare) r_compare <= lane_merge(r_compare, w_wdata, w_be);
            // Software lanes override the tick result; other lanes still advance.
            r_count <= w_wr_count ? lane_merge(w_count_tick, w_wdata, w_be) : w_count_tick;
            r_status[STATUS_MATCH] <= (r_status[STATUS_MATCH] & ~w_status_clr[STATUS_MATCH]) | w_match_set;
            r_status[STATUS_OVF]   <= (r_status[STATUS_OVF]   & ~w_status_clr[STATUS_OVF])   | w_ovf_set;
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        if (cs_i) begin
            case (w_sel)
                TMR_CTRL[3:2]:    rdata_o = r_ctrl;
                TMR_COUNT[3:2]:   rdata_o = r_count;
                TMR_COMPARE[3:2]: rdata_o = r_compare;
                default:          rdata_o = {30'h0, r_status};
            endcase
        end
    end

    assign irq_o = r_ctrl[CTRL_IRQ_EN] & (|r_status);

endmodule

// File: tb/tb_bus_timer.sv
// Directed and randomized checks of bus_timer against a register-level behavioural model.
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [1:0]  hb = 2'b10;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: index 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS; m_since = cycles since prescaler restart.
    logic [31:0] m_reg [4];
    int          m_since;

    always #5 clk = ~clk;

    bus_timer dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .cs_i    (cs),
        .we_i    (we),
        .addr_i  (addr),
        .hb_i    (hb),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .irq_o   (irq)
    );

    task automatic model_edge();
        logic        wr, tick, wr_k;
        logic [1:0]  sel, set, clr;
        logic [7:0]  db;
        logic [31:0] cnt_t;
        int          ps;
        if (rst) begin
            m_reg[0] = 32'h0; m_reg[1] = 32'h0; m_reg[2] = 32'hFFFF_FFFF; m_reg[3] = 32'h0;
            m_since = 0;
            return;
        end
        wr   = cs && we;
        sel  = addr[3:2];
        ps   = int'(m_reg[0][15:8]);
        tick = m_reg[0][0] && !(wr && sel == 2'd0) && ((m_since % (ps + 1)) == ps);
        m_since = (!m_reg[0][0] || (wr && sel == 2'd0)) ? 0 : m_since + 1;
        cnt_t = m_reg[1];
        set   = 2'b00;
        clr   = 2'b00;
        if (tick) begin
            if (m_reg[1] == m_reg[2]) begin
                set[0] = 1'b1;
                cnt_t  = m_reg[0][1] ? 32'h0 : m_reg[1] + 32'd1;
            end else if (m_reg[1] == 32'hFFFF_FFFF) begin
                set[1] = 1'b1;
                cnt_t  = 32'h0;
            end else begin
                cnt_t = m_reg[1] + 32'd1;
            end
        end
        m_reg[1] = cnt_t;
        if (wr) begin
            for (int k = 0; k < 4; k++) begin
                case (hb)
                    2'b00: begin wr_k = (k == int'(addr[1:0])); db = wdata[7:0]; end
                    2'b01: begin wr_k = !addr[0] && ((k / 2) == int'(addr[1])); db = wdata[8*(k%2) +: 8]; end
                    default: begin wr_k = 1'b1; db = wdata[8*k +: 8]; end
                endcase
                if (wr_k) begin
                    if (sel == 2'd3) begin
                        if (k == 0) clr = db[1:0];
                    end else begin
                        m_reg[sel][8*k +: 8] = db;
                    end
                end
            end
        end
        m_reg[0] = m_reg[0] & 32'h0000_FF07;
        m_reg[3] = {30'h0, (m_reg[3][1:0] & ~clr) | set};
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] h, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; addr = a; hb = h; wdata = d;
        step();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input int idx, output logic [31:0] val);
        logic [31:0] t;
        t = $urandom;
        cs = 1'b1; we = 1'b0; hb = 2'b10;
        addr = {t[31:4], 2'(idx), t[1:0]};
        #1;
        val = rdata;
        cs = 1'b0;
    endtask

    task automatic rd_exp(input int idx, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        rd(idx, v);
        chk(tag, v, exp);
    endtask

    task automatic rd_model(input int idx, input string tag);
        logic [31:0] v;
        rd(idx, v);
        chk(tag, v, m_reg[idx]);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        chk(tag, {31'h0, irq}, {31'h0, exp});
    endtask

    initial begin
        logic [31:0] t, d;
        int          sel, act;

        // 1: reset values
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        rd_exp(0, 32'h0, "rst_ctrl");
        rd_exp(1, 32'h0, "rst_count");
        rd_exp(2, 32'hFFFF_FFFF, "rst_compare");
        rd_exp(3, 32'h0, "rst_status");
        chk_irq(1'b0, "rst_irq");
        step();
        chk(" cs_low_rdata", rdata, 32'h0);

        // 2: prescale 3, auto reload, match at 5
        wr(32'h8, 2'b10, 32'd5);
        wr(32'h0, 2'b10, 32'h0000_0307);
        for (int c = 1; c <= 23; c++) begin
            step();
            rd_model(1, "t2_count_model");
            if (c == 4) rd_exp(1, 32'd1, "t2_first_tick");
        end
        rd_exp(1, 32'd5, "t2_count5");
        rd_exp(3, 32'h0, "t2_no_match_yet");
        step();
        rd_exp(1, 32'd0, "t2_reload");
        rd_exp(3, 32'h1, "t2_match");
        chk_irq(1'b1, "t2_irq_hi");
        wr(32'hC, 2'b10, 32'h1);
        chk_irq(1'b0, "t2_irq_cleared");

        // 3: overflow then match at zero
        wr(32'h0, 2'b10, 32'h0);
        wr(32'h4, 2'b10, 32'hFFFF_FFFE);
        wr(32'h8, 2'b10, 32'h0);
        wr(32'hC, 2'b10, 32'h3);
        wr(32'h0, 2'b10, 32'h1);
        step(); step();
        rd_exp(1, 32'h0, "t3_wrap");
        rd_exp(3, 32'h2, "t3_ovf_only");
        step();
        rd_exp(3, 32'h3, "t3_match_zero");
        rd_exp(1, 32'h1, "t3_count_after_match");

        // 4: lane writes, EN off
        wr(32'h0, 2'b10, 32'h0);
        wr(32'h4, 2'b10, 32'h0);
        wr(32'h5, 2'b00, 32'hFFFF_FFAB);
        rd_exp(1, 32'h0000_AB00, "t4_byte");
        wr(32'h6, 2'b01, 32'hFFFF_1234);
        rd_exp(1, 32'h1234_AB00, "t4_half");
        wr(32'h7, 2'b01, 32'h0000_5678);
        rd_exp(1, 32'h1234_AB00, "t4_misaligned");

        // 5: write vs tick, W1C vs set
        wr(32'h8, 2'b10, 32'h200);
        wr(32'hC, 2'b10, 32'h3);
        wr(32'h0, 2'b10, 32'h1);
        step();
        wr(32'h4, 2'b10, 32'h100);
        rd_exp(1, 32'h100, "t5_write_wins");
        step();
        rd_exp(1, 32'h101, "t5_next_tick");
        wr(32'h0, 2'b10, 32'h0);
        wr(32'h4, 2'b10, 32'h0);
        wr(32'h8, 2'b10, 32'h0);
        wr(32'h0, 2'b10, 32'h3);
        step();
        rd_exp(3, 32'h1, "t5_match_set");
        wr(32'hC, 2'b10, 32'h1);
        rd_exp(3, 32'h1, "t5_set_beats_clear");

        // 6: reset mid-count
        wr(32'h0, 2'b10, 32'h7);
        step();
        chk_irq(1'b1, "t6_irq_before_rst");
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_exp(0, 32'h0, "t6_ctrl");
        rd_exp(1, 32'h0, "t6_count");
        rd_exp(2, 32'hFFFF_FFFF, "t6_compare");
        rd_exp(3, 32'h0, "t6_status");
        chk_irq(1'b0, "t6_irq");
        for (int c = 0; c < 5; c++) step();
        rd_exp(1, 32'h0, "t6_no_tick");

        // Random traffic against the model
        for (int it = 0; it < 600; it++) begin
            act = int'($urandom_range(0, 9));
            if (act < 3) begin
                sel = int'($urandom_range(0, 3));
                t   = $urandom;
                d   = $urandom;
                if (sel == 0) begin
                    d = (d & 32'hFFFF_00FF) | (32'($urandom_range(0, 3)) << 8);
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                    wr({t[31:4], 2'd0, t[1:0]}, 2'b10, d);
                end else begin
                    if (sel == 2) d = m_reg[1] + 32'($urandom_range(0, 12));
                    if (sel == 1 && $urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 | (d & 32'hF);
                    wr({t[31:4], 2'(sel), t[1:0]}, 2'($urandom_range(0, 3)), d);
                end
            end else if (act < 9) begin
                rd_model(int'($urandom_range(0, 3)), "rand_read");
                step();
            end else begin
                step();
                chk("rand_cs_low", rdata, 32'h0);
            end
            chk_irq(m_reg[0][2] & (|m_reg[3][1:0]), "rand_irq");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
